// File: rtl/cascade_inta_sequencer.sv
// 8259A INTA-cycle sequencer (8086 mode): captures the acknowledged IR on the first INTA pulse,
// drives CAS in cascaded master mode, and places the vector byte during the second pulse.
module cascade_inta_sequencer #(
    parameter int CAS_W = 3,
    parameter int VEC_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     INTA_n,
    input  logic                     SP,
    input  logic [(1<<CAS_W)-1:0]    ICW3,
    input  logic                     int_pending,
    input  logic [CAS_W-1:0]         highest_ir,
    input  logic [VEC_W-CAS_W-1:0]   vector_base,
    input  logic [CAS_W-1:0]         CAS_in,
    output logic [CAS_W-1:0]         CAS_out,
    output logic                     CAS_oe,
    output logic [VEC_W-1:0]         D_out,
    output logic                     D_oe,
    output logic                     latch_isr,
    output logic [CAS_W-1:0]         ack_ir,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK1,
        S_GAP,
        S_ACK2
    } state_t;

    state_t             r_state;
    logic               r_inta_q;
    logic               r_mode_q;
    logic [CAS_W-1:0]   r_ir_q;
    logic               r_spur_q;
    logic               r_casc_q;
    logic               r_sel_q;
    logic [CAS_W-1:0]   r_cas_out;
    logic               r_cas_oe;
    logic [VEC_W-1:0]   r_d_out;
    logic               r_d_oe;
    logic               r_latch;

    logic               w_fall;
    logic               w_rise;
    logic [CAS_W-1:0]   w_ir_sel;
    logic               w_casc;
    logic               w_sel;

    assign w_fall   = r_inta_q & ~INTA_n;
    assign w_rise   = ~r_inta_q & INTA_n;
    // Spurious acknowledges are reported as the lowest-priority IR.
    assign w_ir_sel = int_pending ? highest_ir : '1;
    assign w_casc   = SP & int_pending & ICW3[highest_ir];
    assign w_sel    = (CAS_in == ICW3[CAS_W-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_inta_q  <= 1'b1;
            r_mode_q  <= 1'b0;
            r_ir_q    <= '0;
            r_spur_q  <= 1'b0;
            r_casc_q  <= 1'b0;
            r_sel_q   <= 1'b0;
            r_cas_out <= '0;
            r_cas_oe  <= 1'b0;
            r_d_out   <= '0;
            r_d_oe    <= 1'b0;
            r_latch   <= 1'b0;
        end else begin
            r_inta_q <= INTA_n;
            r_latch  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state  <= S_ACK1;
                        r_mode_q <= SP;
                        r_ir_q   <= w_ir_sel;
                        r_spur_q <= ~int_pending;
                        r_casc_q <= w_casc;
                        r_sel_q  <= 1'b0;
                        r_latch  <= SP & int_pending;
                        if (w_casc) begin
                            r_cas_out <= highest_ir;
                            r_cas_oe  <= 1'b1;
                        end
                    end
                end
                S_ACK1: begin
                    if (w_rise) begin
                        r_state <= S_GAP;
                        if (!r_mode_q) begin
                            r_sel_q <= w_sel;
                            r_latch <= w_sel & ~r_spur_q;
                        end
                    end
                end
                S_GAP: begin
                    if (w_fall) begin
                        r_state <= S_ACK2;
                        // A cascaded master leaves the vector to the selected slave.
                        if (r_mode_q ? ~r_casc_q : r_sel_q) begin
                            r_d_out <= {vector_base, r_ir_q};
                            r_d_oe  <= 1'b1;
                        end
                    end
                end
                S_ACK2: begin
                    if (w_rise) begin
                        r_state  <= S_IDLE;
                        r_cas_oe <= 1'b0;
                        r_d_oe   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CAS_out   = r_cas_out;
    assign CAS_oe    = r_cas_oe;
    assign D_out     = r_d_out;
    assign D_oe      = r_d_oe;
    assign latch_isr = r_latch;
    assign ack_ir    = r_ir_q;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cascade_inta_sequencer.sv
// Self-checking bench for cascade_inta_sequencer: each INTA sequence is checked cycle by cycle
// against output windows derived from pulse boundaries and the values captured at the first fall.
module tb_cascade_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       INTA_n;
    logic       SP;
    logic [7:0] ICW3;
    logic       int_pending;
    logic [2:0] highest_ir;
    logic [4:0] vector_base;
    logic [2:0] CAS_in;
    logic [2:0] CAS_out;
    logic       CAS_oe;
    logic [7:0] D_out;
    logic       D_oe;
    logic       latch_isr;
    logic [2:0] ack_ir;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Last values the bus drivers were loaded with; they persist while disabled.
    logic [7:0] m_dout;
    logic [2:0] m_cas;

    always #5 clk = ~clk;

    cascade_inta_sequencer #(.CAS_W(3), .VEC_W(8)) dut (
        .clk(clk), .reset(reset), .INTA_n(INTA_n), .SP(SP), .ICW3(ICW3),
        .int_pending(int_pending), .highest_ir(highest_ir), .vector_base(vector_base),
        .CAS_in(CAS_in), .CAS_out(CAS_out), .CAS_oe(CAS_oe), .D_out(D_out), .D_oe(D_oe),
        .latch_isr(latch_isr), .ack_ir(ack_ir), .busy(busy)
    );

    // One full INTA sequence: pulse 1 low for l1 cycles, high for g, pulse 2 low for l2, then one
    // high cycle. Sample j reflects the registers updated by the edge after INTA_n takes wave[j].
    task automatic run_seq(input logic sp, input logic [7:0] icw3, input logic pend,
                           input logic [2:0] ir, input logic [4:0] base, input logic [2:0] casin,
                           input int l1, input int g, input int l2, input logic tog);
        logic [2:0] e_ir;
        logic       e_spur, e_casc, e_sel, e_drive;
        int         latch_at, n_end;
        logic       e_busy, e_cas_oe, e_d_oe, e_latch;
        e_ir     = pend ? ir : 3'd7;
        e_spur   = ~pend;
        e_casc   = sp & pend & icw3[ir];
        e_sel    = (casin == icw3[2:0]);
        e_drive  = sp ? ~e_casc : e_sel;
        latch_at = -1;
        if (sp && !e_spur) latch_at = 0;
        if (!sp && e_sel && !e_spur) latch_at = l1;
        n_end = l1 + g + l2;
        for (int j = 0; j <= n_end; j++) begin
            @(negedge clk);
            if (j == 0) begin
                SP = sp; ICW3 = icw3; int_pending = pend; highest_ir = ir;
                vector_base = base; CAS_in = casin;
            end
            if (j == 1 && tog) begin
                SP = ~sp; highest_ir = 3'($urandom); int_pending = 1'($urandom);
            end
            INTA_n = (j < l1) ? 1'b0 : (j < l1 + g) ? 1'b1 : (j < n_end) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            e_busy   = (j < n_end);
            e_cas_oe = e_casc && e_busy;
            e_d_oe   = e_drive && e_busy && (j >= l1 + g);
            e_latch  = (j == latch_at);
            if (e_cas_oe) m_cas = e_ir;
            if (e_d_oe) m_dout = {base, e_ir};
            checks++;
            if (busy !== e_busy) begin
                failures++; $display("FAIL busy j=%0d got=%0b exp=%0b", j, busy, e_busy);
            end
            checks++;
            if (latch_isr !== e_latch) begin
                failures++; $display("FAIL latch_isr j=%0d got=%0b exp=%0b", j, latch_isr, e_latch);
            end
            checks++;
            if (CAS_oe !== e_cas_oe) begin
                failures++; $display("FAIL CAS_oe j=%0d got=%0b exp=%0b", j, CAS_oe, e_cas_oe);
            end
            checks++;
            if (D_oe !== e_d_oe) begin
                failures++; $display("FAIL D_oe j=%0d got=%0b exp=%0b", j, D_oe, e_d_oe);
            end
            checks++;
            if (D_out !== m_dout) begin
                failures++; $display("FAIL D_out j=%0d got=%02h exp=%02h", j, D_out, m_dout);
            end
            checks++;
            if (CAS_out !== m_cas) begin
                failures++; $display("FAIL CAS_out j=%0d got=%0d exp=%0d", j, CAS_out, m_cas);
            end
            if (e_busy) begin
                checks++;
                if (ack_ir !== e_ir) begin
                    failures++; $display("FAIL ack_ir j=%0d got=%0d exp=%0d", j, ack_ir, e_ir);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({busy, latch_isr, CAS_oe, D_oe, CAS_out, D_out, ack_ir} !== 17'd0) begin
            failures++;
            $display("FAIL %s_zero got busy=%0b latch=%0b cas_oe=%0b d_oe=%0b cas=%0d d=%02h ir=%0d exp all 0",
                     tag, busy, latch_isr, CAS_oe, D_oe, CAS_out, D_out, ack_ir);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; INTA_n = 1'b1; SP = 1'b1; ICW3 = '0; int_pending = 1'b0;
        highest_ir = '0; vector_base = '0; CAS_in = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        m_dout = '0; m_cas = '0;
        repeat (2) @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_master_nocasc();
        run_seq(1'b1, 8'h00, 1'b1, 3'd3, 5'h08, 3'd0, 2, 2, 3, 1'b0);
        checks++;
        if (D_out !== 8'h43) begin
            failures++; $display("FAIL master_vec got=%02h exp=43", D_out);
        end
    endtask

    task automatic test_master_casc();
        run_seq(1'b1, 8'h04, 1'b1, 3'd2, 5'h08, 3'd0, 3, 2, 2, 1'b0);
        checks++;
        if (CAS_out !== 3'd2) begin
            failures++; $display("FAIL master_cas got=%0d exp=2", CAS_out);
        end
    endtask

    task automatic test_slave();
        run_seq(1'b0, 8'h02, 1'b1, 3'd5, 5'h10, 3'd2, 2, 3, 2, 1'b0);
        checks++;
        if (D_out !== 8'h85) begin
            failures++; $display("FAIL slave_vec got=%02h exp=85", D_out);
        end
        run_seq(1'b0, 8'h02, 1'b1, 3'd5, 5'h11, 3'd3, 2, 1, 2, 1'b0);
        checks++;
        if (D_out !== 8'h85) begin
            failures++; $display("FAIL slave_unsel_hold got=%02h exp=85", D_out);
        end
    endtask

    task automatic test_spurious();
        run_seq(1'b1, 8'hFF, 1'b0, 3'd1, 5'h1A, 3'd0, 1, 1, 1, 1'b0);
        checks++;
        if (D_out !== 8'hD7) begin
            failures++; $display("FAIL spurious_vec got=%02h exp=d7", D_out);
        end
    endtask

    task automatic test_reset_midseq();
        @(negedge clk);
        SP = 1'b1; ICW3 = 8'h04; int_pending = 1'b1; highest_ir = 3'd2; vector_base = 5'h08;
        INTA_n = 1'b0;
        repeat (2) @(negedge clk);
        INTA_n = 1'b1;
        @(negedge clk);
        checks++;
        if (!(CAS_oe === 1'b1 && busy === 1'b1)) begin
            failures++; $display("FAIL gap_before_reset got cas_oe=%0b busy=%0b exp 1 1", CAS_oe, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midseq_reset");
        reset = 1'b0;
        m_dout = '0; m_cas = '0;
        run_seq(1'b1, 8'h00, 1'b1, 3'd6, 5'h03, 3'd0, 2, 2, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 40; k++) begin
            run_seq(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 3'($urandom),
                    5'($urandom), 3'($urandom), $urandom_range(1, 4), $urandom_range(1, 4),
                    $urandom_range(1, 4), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b0) begin
                    failures++; $display("FAIL idle_between got=%0b exp=0", busy);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; INTA_n = 1'b1; SP = 1'b0; ICW3 = '0; int_pending = 1'b0;
        highest_ir = '0; vector_base = '0; CAS_in = '0;
        m_dout = '0; m_cas = '0;
        test_reset();
        test_master_nocasc();
        test_master_casc();
        test_slave();
        test_spurious();
        test_reset_midseq();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
